// File: rtl/merge_result_scheduler_pkg.sv
// Shared types for the merge result scheduler: field widths, the stored result entry
// and the sequence-check FSM state encoding.
package merge_result_scheduler_pkg;

   localparam int PKT_NUM_W  = 4;
   localparam int ZERO_NUM_W = 12;
   localparam int CRC_W      = 32;

   typedef struct packed {
      logic [PKT_NUM_W-1:0]  packet_num;
      logic [ZERO_NUM_W-1:0] zero_num;
      logic [CRC_W-1:0]      crc;
   } result_t;

   typedef enum logic {
      SEQ_SYNC  = 1'b0,
      SEQ_TRACK = 1'b1
   } seq_state_t;

   function automatic logic [PKT_NUM_W-1:0] next_seq(input logic [PKT_NUM_W-1:0] pn);
      return pn + 1'b1;
   endfunction

endpackage

// File: rtl/merge_result_scheduler_if.sv
// Bus between the merge crossbar, the result scheduler and the compare stage.
// master = surrounding pipeline, slave = scheduler.
interface merge_result_scheduler_if
   import merge_result_scheduler_pkg::*;
#(
   parameter int PKT_NUM = 8,
   parameter int CRC_W   = 32
);
   logic [PKT_NUM-1:0]            in_sop;
   logic [PKT_NUM-1:0]            in_eop;
   logic [PKT_NUM-1:0]            in_dval;
   logic [PKT_NUM_W*PKT_NUM-1:0]  in_packet_num;
   logic [ZERO_NUM_W*PKT_NUM-1:0] in_zero_num;
   logic [CRC_W*PKT_NUM-1:0]      in_dout;
   logic                          in_ready;
   logic                          out_valid;
   logic                          out_ready;
   logic [PKT_NUM_W-1:0]          out_packet_num;
   logic [ZERO_NUM_W-1:0]         out_zero_num;
   logic [CRC_W-1:0]              out_crc;
   logic                          overflow;
   logic                          seq_err;
   logic [31:0]                   pkt_cnt;
   logic [15:0]                   drop_cnt;

   modport master (
      output in_sop, in_eop, in_dval, in_packet_num, in_zero_num, in_dout, out_ready,
      input  in_ready, out_valid, out_packet_num, out_zero_num, out_crc,
             overflow, seq_err, pkt_cnt, drop_cnt
   );

   modport slave (
      input  in_sop, in_eop, in_dval, in_packet_num, in_zero_num, in_dout, out_ready,
      output in_ready, out_valid, out_packet_num, out_zero_num, out_crc,
             overflow, seq_err, pkt_cnt, drop_cnt
   );

endinterface

// File: rtl/merge_result_scheduler_compactor.sv
// merge_lane_compactor: combinational prefix popcount of the candidate mask, giving each
// lane its slot offset from wr_ptr plus the total number of pushes.
module merge_lane_compactor #(
   parameter int PKT_NUM = 8,
   parameter int CNT_W   = $clog2(PKT_NUM + 1)
) (
   input  logic [PKT_NUM-1:0]            i_cand,
   output logic [PKT_NUM-1:0][CNT_W-1:0] o_offset,
   output logic [CNT_W-1:0]              o_push_cnt
);

   logic [CNT_W-1:0] w_acc;

   always_comb begin
      o_offset = '0;
      w_acc    = '0;
      for (int k = 0; k < PKT_NUM; k++) begin
         o_offset[k] = w_acc;
         w_acc       = w_acc + CNT_W'(i_cand[k]);
      end
      o_push_cnt = w_acc;
   end

endmodule

// File: rtl/merge_result_scheduler.sv
// Compacts per-lane merge results into a shared FIFO, drains it one per cycle and
// checks sequence continuity. MERGE_SCHED_STATS_EN adds delivered/dropped counters.
//
//   state     | meaning
//   SEQ_SYNC  | no result popped since reset; next pop only seeds r_exp_num
//   SEQ_TRACK | each pop compared with r_exp_num, then r_exp_num reloaded
module merge_result_scheduler
   import merge_result_scheduler_pkg::*;
#(
   parameter int PKT_NUM    = 8,
   parameter int FIFO_DEPTH = 32,
   parameter int CRC_W      = merge_result_scheduler_pkg::CRC_W
) (
   input logic                     clk,
   input logic                     rst,
   merge_result_scheduler_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int PC_W  = $clog2(PKT_NUM + 1);

   result_t                       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]              r_wr_ptr;
   logic [PTR_W-1:0]              r_rd_ptr;
   logic [CNT_W-1:0]              r_count;
   logic                          r_overflow;
   seq_state_t                    r_seq_state;
   logic [PKT_NUM_W-1:0]          r_exp_num;
   logic                          r_seq_err;

   logic [PKT_NUM-1:0]            w_cand;
   logic [PKT_NUM-1:0][PC_W-1:0]  w_offset;
   logic [PC_W-1:0]               w_push_cnt;
   logic [CNT_W-1:0]              w_free;
   logic [CNT_W-1:0]              w_push;
   logic                          w_in_ready;
   logic                          w_wr_en;
   logic                          w_drop;
   logic                          w_out_valid;
   logic                          w_pop;
   result_t                       w_head;
   logic                          w_unused_sop;

   assign w_unused_sop = ^bus.in_sop;
   assign w_cand       = bus.in_dval & bus.in_eop;

   merge_lane_compactor #(
      .PKT_NUM (PKT_NUM),
      .CNT_W   (PC_W)
   ) u_compactor (
      .i_cand     (w_cand),
      .o_offset   (w_offset),
      .o_push_cnt (w_push_cnt)
   );

   // Readiness comes from registered count only, so a full FIFO blocks writes even if it pops.
   assign w_free      = CNT_W'(FIFO_DEPTH) - r_count;
   assign w_in_ready  = (w_free >= CNT_W'(PKT_NUM));
   assign w_wr_en     = (|w_cand) & w_in_ready;
   assign w_drop      = (|w_cand) & ~w_in_ready;
   assign w_push      = w_wr_en ? CNT_W'(w_push_cnt) : '0;
   assign w_out_valid = (r_count != '0);
   assign w_pop       = w_out_valid & bus.out_ready;
   assign w_head      = w_out_valid ? r_mem[r_rd_ptr] : '0;

   assign bus.in_ready       = w_in_ready;
   assign bus.out_valid      = w_out_valid;
   assign bus.out_packet_num = w_head.packet_num;
   assign bus.out_zero_num   = w_head.zero_num;
   assign bus.out_crc        = w_head.crc;
   assign bus.overflow       = r_overflow;
   assign bus.seq_err        = r_seq_err;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int k = 0; k < PKT_NUM; k++) begin
            if (w_cand[k]) begin
               r_mem[r_wr_ptr + PTR_W'(w_offset[k])] <= '{
                  packet_num: bus.in_packet_num[k*PKT_NUM_W +: PKT_NUM_W],
                  zero_num:   bus.in_zero_num[k*ZERO_NUM_W +: ZERO_NUM_W],
                  crc:        bus.in_dout[k*CRC_W +: CRC_W]
               };
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + w_push - CNT_W'(w_pop);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seq_state <= SEQ_SYNC;
         r_exp_num   <= '0;
         r_seq_err   <= 1'b0;
      end else if (w_pop) begin
         r_exp_num <= next_seq(w_head.packet_num);
         case (r_seq_state)
            SEQ_SYNC:  r_seq_state <= SEQ_TRACK;
            SEQ_TRACK: begin
               if (w_head.packet_num != r_exp_num) begin
                  r_seq_err <= 1'b1;
               end
            end
            default:   r_seq_state <= SEQ_SYNC;
         endcase
      end
   end

`ifdef MERGE_SCHED_STATS_EN
   logic [31:0] r_pkt_cnt;
   logic [15:0] r_drop_cnt;
   logic [16:0] w_drop_sum;

   assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_push_cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_pop) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
         end
         if (w_drop) begin
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
         end
      end
   end

   assign bus.pkt_cnt  = r_pkt_cnt;
   assign bus.drop_cnt = r_drop_cnt;
`else
   assign bus.pkt_cnt  = '0;
   assign bus.drop_cnt = '0;
`endif

endmodule
